// File: rtl/ex_mem_fwd_reg.sv
// EX/MEM pipeline register with forwarding-unit selects and halt-drain FSM.
// Optional macro WB_FORWARDING_EN enables forwarding from the MEM/WB stage.
module ex_mem_fwd_reg #(
    parameter int DATA_SIZE    = 32,
    parameter int PC_SIZE      = 32,
    parameter int REG_SIZE     = 5,
    parameter int MUX_SEL_SIZE = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_flush,
    input  logic                    i_reg_write,
    input  logic                    i_mem_to_reg,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_branch,
    input  logic                    i_jump,
    input  logic                    i_halt,
    input  logic                    i_zero,
    input  logic [3:0]              i_size_ctrl,
    input  logic [DATA_SIZE-1:0]    i_alu_result,
    input  logic [DATA_SIZE-1:0]    i_data_b,
    input  logic [PC_SIZE-1:0]      i_branch_addr,
    input  logic [PC_SIZE-1:0]      i_pc,
    input  logic [REG_SIZE-1:0]     i_selected_reg,
    input  logic [REG_SIZE-1:0]     i_id_ex_rs,
    input  logic [REG_SIZE-1:0]     i_id_ex_rt,
    input  logic                    i_id_ex_mem_write,
    input  logic                    i_wb_reg_write,
    input  logic [REG_SIZE-1:0]     i_wb_reg,
    output logic                    o_valid,
    output logic                    o_reg_write,
    output logic                    o_mem_to_reg,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_jump,
    output logic [3:0]              o_size_ctrl,
    output logic [DATA_SIZE-1:0]    o_alu_result,
    output logic [DATA_SIZE-1:0]    o_data_b,
    output logic [PC_SIZE-1:0]      o_pc,
    output logic [REG_SIZE-1:0]     o_selected_reg,
    output logic                    o_pc_src,
    output logic [PC_SIZE-1:0]      o_branch_addr,
    output logic [MUX_SEL_SIZE-1:0] o_fwd_a,
    output logic [MUX_SEL_SIZE-1:0] o_fwd_b,
    output logic [MUX_SEL_SIZE-1:0] o_forwarding_mux,
    output logic                    o_halted
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;

    localparam logic [MUX_SEL_SIZE-1:0] SEL_0 = MUX_SEL_SIZE'(0);
    localparam logic [MUX_SEL_SIZE-1:0] SEL_1 = MUX_SEL_SIZE'(1);
    localparam logic [MUX_SEL_SIZE-1:0] SEL_2 = MUX_SEL_SIZE'(2);

    halt_state_t state, state_next;
    logic [1:0]  drain_cnt, drain_cnt_next;
    logic        branch_q, zero_q;
    logic        mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_reg_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_jump         <= 1'b0;
            branch_q       <= 1'b0;
            zero_q         <= 1'b0;
            o_size_ctrl    <= '0;
            o_alu_result   <= '0;
            o_data_b       <= '0;
            o_pc           <= '0;
            o_branch_addr  <= '0;
            o_selected_reg <= '0;
        end else if (i_enable) begin
            // Data fields are captured even on flush; o_valid gates their meaning.
            o_mem_to_reg   <= i_mem_to_reg;
            branch_q       <= i_branch;
            zero_q         <= i_zero;
            o_size_ctrl    <= i_size_ctrl;
            o_alu_result   <= i_alu_result;
            o_data_b       <= i_data_b;
            o_pc           <= i_pc;
            o_branch_addr  <= i_branch_addr;
            o_selected_reg <= i_selected_reg;
            if (i_flush) begin
                o_valid     <= 1'b0;
                o_reg_write <= 1'b0;
                o_mem_read  <= 1'b0;
                o_mem_write <= 1'b0;
                o_jump      <= 1'b0;
            end else begin
                o_valid     <= 1'b1;
                o_reg_write <= i_reg_write;
                o_mem_read  <= i_mem_read;
                o_mem_write <= i_mem_write;
                o_jump      <= i_jump;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (i_enable) begin
            case (state)
                RUN: begin
                    if (i_halt && !i_flush) begin
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) state_next = HALTED;
                    else                   drain_cnt_next = drain_cnt + 2'd1;
                end
                HALTED:  state_next = HALTED;
                default: state_next = RUN;
            endcase
        end
    end

    assign o_halted = (state == HALTED);
    assign o_pc_src = o_valid & branch_q & zero_q;

    assign mem_hit_a = o_valid && o_reg_write && (o_selected_reg != '0) && (o_selected_reg == i_id_ex_rs);
    assign mem_hit_b = o_valid && o_reg_write && (o_selected_reg != '0) && (o_selected_reg == i_id_ex_rt);

`ifdef WB_FORWARDING_EN
    assign wb_hit_a = i_wb_reg_write && (i_wb_reg != '0) && (i_wb_reg == i_id_ex_rs);
    assign wb_hit_b = i_wb_reg_write && (i_wb_reg != '0) && (i_wb_reg == i_id_ex_rt);
`else
    logic unused_wb;
    assign unused_wb = ^{i_wb_reg_write, i_wb_reg};
    assign wb_hit_a  = 1'b0;
    assign wb_hit_b  = 1'b0;
`endif

    always_comb begin
        o_fwd_a          = SEL_0;
        o_fwd_b          = SEL_0;
        o_forwarding_mux = SEL_2;
        if (mem_hit_a)     o_fwd_a = SEL_1;
        else if (wb_hit_a) o_fwd_a = SEL_2;
        if (mem_hit_b)     o_fwd_b = SEL_1;
        else if (wb_hit_b) o_fwd_b = SEL_2;
        if (i_id_ex_mem_write && mem_hit_b)     o_forwarding_mux = SEL_0;
        else if (i_id_ex_mem_write && wb_hit_b) o_forwarding_mux = SEL_1;
    end

endmodule

// File: doc/ex_mem_fwd_reg.md
EX_MEM_FWD_REG -- requirements
Module: ex_mem_fwd_reg

Interface
REQ-001 Parameters: DATA_SIZE 32, data width; PC_SIZE 32, PC/branch-address width; REG_SIZE 5, register-index width; MUX_SEL_SIZE 2, forwarding-select width.
REQ-002 One clock; reset is asynchronous and active-low: i_clk in 1, rising-edge clock; i_rst_n in 1, asynchronous active-low reset.
REQ-003 i_enable in 1, pipeline advance (debug-unit step/run); i_flush in 1, inserts bubble.
REQ-004 i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write, i_branch, i_jump, i_halt, i_zero in 1 each, EX-stage flags.
REQ-005 i_size_ctrl in 4, {signed, byte, halfword, word} from EX.
REQ-006 i_alu_result, i_data_b in DATA_SIZE; i_branch_addr, i_pc in PC_SIZE; i_selected_reg in REG_SIZE.
REQ-007 i_id_ex_rs, i_id_ex_rt in REG_SIZE, source registers of the instruction now in EX; i_id_ex_mem_write in 1, that instruction is a store.
REQ-008 i_wb_reg_write in 1, i_wb_reg in REG_SIZE, MEM/WB destination.
REQ-009 o_valid out 1; o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write, o_jump out 1; o_size_ctrl out 4; o_alu_result, o_data_b out DATA_SIZE; o_pc out PC_SIZE; o_selected_reg out REG_SIZE: registered EX/MEM fields.
REQ-010 o_pc_src out 1, branch taken; o_branch_addr out PC_SIZE.
REQ-011 o_fwd_a, o_fwd_b, o_forwarding_mux out MUX_SEL_SIZE, combinational selects to EX.
REQ-012 o_halted out 1, pipeline drained after halt.

Function
REQ-013 On rising edge with i_enable=1, i_flush=0: all i_* EX fields captured into o_* registers, o_valid<=1; one-cycle latency.
REQ-014 i_enable=1, i_flush=1: o_valid, o_reg_write, o_mem_read, o_mem_write, o_jump, captured halt <=0; data fields don't-care; flush wins over capture.
REQ-015 i_enable=0: all registers hold, including FSM and counter; i_flush ignored.
REQ-016 o_pc_src = o_valid & branch_q & zero_q; o_branch_addr = registered i_branch_addr.
REQ-017 MEM hit A: o_valid & o_reg_write & o_selected_reg!=0 & o_selected_reg==i_id_ex_rs; WB hit A: i_wb_reg_write & i_wb_reg!=0 & i_wb_reg==i_id_ex_rs; same for B with i_id_ex_rt.
REQ-018 o_fwd_a/o_fwd_b: MEM hit -> 01, else WB hit -> 10, else 00; MEM priority on double hit; 11 never driven.
REQ-019 o_forwarding_mux: i_id_ex_mem_write & MEM hit B -> 00, else i_id_ex_mem_write & WB hit B -> 01, else 10.
REQ-020 Halt FSM states RUN, DRAIN, HALTED; RUN->DRAIN on enabled edge capturing i_halt=1 with i_flush=0.
REQ-021 DRAIN: 2-bit counter loaded 0, increments per enabled edge; at value 2 -> HALTED (three enabled edges after capture).
REQ-022 HALTED: o_halted=1, absorbing until reset; captures continue but further i_halt ignored.
REQ-023 o_halted=0 in RUN and DRAIN.

Reset
REQ-024 i_rst_n=0 asynchronously clears all registered outputs to 0, o_valid=0, FSM=RUN, counter=0, including mid-DRAIN.
REQ-025 During reset o_pc_src=0, o_fwd_a=o_fwd_b=00, o_forwarding_mux=10 unless WB hit.
REQ-026 Reset release synchronous to next i_clk edge; first capture on first enabled edge after release.

Configuration
REQ-027 Macro WB_FORWARDING_EN: defined -> REQ-017..019 as written; undefined -> WB hits forced 0, o_fwd_a/o_fwd_b in {00,01}, o_forwarding_mux in {00,10}.

Verification
REQ-028 Capture: i_alu_result=0x0000_00A5, i_selected_reg=7, i_reg_write=1, enable -> next cycle o_alu_result=0xA5, o_selected_reg=7, o_valid=1.
REQ-029 Forward: EX/MEM reg 7 writing, i_id_ex_rs=7, i_wb_reg=7 writing -> o_fwd_a=01; EX/MEM reg 0 -> o_fwd_a=10 (00 without WB_FORWARDING_EN).
REQ-030 Store data: i_id_ex_mem_write=1, i_id_ex_rt=9, only WB writes 9 -> o_forwarding_mux=01; no hit -> 10.
REQ-031 Branch: i_branch=1, i_zero=1, i_branch_addr=0x40 -> o_pc_src=1, o_branch_addr=0x40; same with i_flush=1 -> o_pc_src=0, o_valid=0.
REQ-032 Halt: i_halt=1 captured, i_enable toggling 1,0,1,1 -> o_halted=1 only after the third enabled edge post-capture.
REQ-033 Reset in DRAIN: i_rst_n=0 one edge after halt capture -> o_halted=0, o_valid=0 immediately; new halt needs full drain.
